// File: rtl/ifu_pc_gen.sv
// ---------------------------------------------------------------------------
// ifu_pc_gen
//
// Fetch-address generator for the in-order core's instruction fetch unit.
// It holds the current fetch PC, presents it to the instruction ROM, and
// statically predecodes the returned instruction to predict the next PC.
// It also owns the branch-shadow counter. That counter produces a one-cycle
// end pulse so IF/ID knows when squashing after an EXU redirect may stop.
//
// Optional feature macro: IFU_STATIC_BP_EN
//   defined   : JAL and backward conditional branches are predicted taken.
//   undefined : no predecode; the successor is always pc_o + 4, never taken.
//
// Parameters
//   BOOT_ADDR         PC loaded by reset.
//   SLOT_CYCLES       Unstalled branch-shadow cycles after a branch redirect
//                     (legal range 1..7).
//
// Ports
//   clk_i               core clock
//   rst_i               synchronous active-high reset
//   stall_i[5:0]        ctrl stall vector; only bit 0 (hold PC) is used here
//   flush_i             ctrl flush (trap/exception)
//   ctrl_redirect_pc_i  ctrl redirect request (trap entry, mret)
//   ctrl_pc_i           ctrl redirect target
//   branch_redirect_i   EXU misprediction redirect
//   branch_pc_i         EXU corrected target
//   inst_i              ROM data for pc_o, valid in the same cycle
//   pc_o                current fetch PC (registered)
//   next_pc_o           predicted successor of pc_o (combinational)
//   next_taken_o        prediction is a redirect rather than pc_o + 4
//   branch_slot_end_o   pulse on the last branch-shadow cycle
// ---------------------------------------------------------------------------
module ifu_pc_gen #(
  parameter logic [31:0] BOOT_ADDR   = 32'h0000_0000,
  parameter int unsigned SLOT_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [5:0]  stall_i,
  input  logic        flush_i,
  input  logic        ctrl_redirect_pc_i,
  input  logic [31:0] ctrl_pc_i,
  input  logic        branch_redirect_i,
  input  logic [31:0] branch_pc_i,
  input  logic [31:0] inst_i,
  output logic [31:0] pc_o,
  output logic [31:0] next_pc_o,
  output logic        next_taken_o,
  output logic        branch_slot_end_o
);

  // Fetch-unit states.
  // BOOT lasts a single cycle after reset so the ROM sees BOOT_ADDR once
  // before fetch starts advancing.
  // SLOT marks the branch shadow that follows an EXU redirect.
  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_SLOT = 2'd2;

  localparam logic [2:0] SLOT_INIT = 3'(SLOT_CYCLES);

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  logic [1:0]  state_q;
  logic [1:0]  state_d;
  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic [2:0]  slotCnt_q;
  logic [2:0]  slotCnt_d;

  logic        holdPc;
  logic        ctrlRedirect;
  logic [31:0] seqPc;
  logic [31:0] predPc;
  logic        predTaken;

  // Only bit 0 of the stall vector concerns the PC.
  // The other bits belong to downstream stages and are ignored here.
  logic        unusedStallBits;
  assign unusedStallBits = ^stall_i[5:1];

  assign holdPc       = stall_i[0];
  assign ctrlRedirect = flush_i | ctrl_redirect_pc_i;

  // The sequential successor wraps modulo 2^32 because of the 32-bit add.
  assign seqPc = pc_q + 32'd4;

`ifdef IFU_STATIC_BP_EN
  // Static predecode of the instruction returned for pc_q.
  // The J and B immediates are rebuilt from their scrambled encodings and
  // sign-extended to 32 bits.
  // Only backward conditional branches (sign bit set) are predicted taken,
  // the usual loop heuristic.
  logic        isJal;
  logic        isBackBranch;
  logic [31:0] jImm;
  logic [31:0] bImm;
  logic [31:0] jalTarget;
  logic [31:0] branchTarget;

  assign isJal        = (inst_i[6:0] == OPC_JAL);
  assign isBackBranch = (inst_i[6:0] == OPC_BRANCH) && inst_i[31];

  assign jImm = {{12{inst_i[31]}}, inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
  assign bImm = {{20{inst_i[31]}}, inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};

  assign jalTarget    = (pc_q + jImm) & ~32'h1;
  assign branchTarget = (pc_q + bImm) & ~32'h1;

  // Pick the predicted successor.
  // In BOOT the ROM word is not trusted yet, so prediction is suppressed.
  always_comb begin
    predPc    = seqPc;
    predTaken = 1'b0;
    if (state_q != ST_BOOT) begin
      if (isJal) begin
        predPc    = jalTarget;
        predTaken = 1'b1;
      end else if (isBackBranch) begin
        predPc    = branchTarget;
        predTaken = 1'b1;
      end
    end
  end
`else
  // Without static prediction the fetch stream is purely sequential.
  // The ROM word is therefore not needed by this block.
  logic unusedInst;
  assign unusedInst = ^inst_i;

  always_comb begin
    predPc    = seqPc;
    predTaken = 1'b0;
  end
`endif

  assign pc_o         = pc_q;
  assign next_pc_o    = predPc;
  assign next_taken_o = predTaken;

  // End-of-shadow pulse on the last unstalled shadow cycle.
  // A same-cycle branch redirect still lets it through, so IF/ID sees the
  // first redirect's pulse.
  // Reset or a ctrl flush/redirect abandons the shadow, so no pulse is
  // produced in that cycle.
  assign branch_slot_end_o = (state_q == ST_SLOT) && (slotCnt_q == 3'd1) &&
                             !holdPc && !rst_i && !ctrlRedirect;

  // Next-state logic. Priority, highest first:
  //   - ctrl flush/redirect: jump to ctrl_pc_i and leave any shadow.
  //   - branch redirect: jump to branch_pc_i and (re)start the shadow.
  //   - per-state behaviour: BOOT always moves to RUN.
  //     RUN and SLOT advance only while not stalled.
  //     SLOT additionally counts down its shadow.
  // Redirects ignore the stall bit so a corrected path is never lost.
  always_comb begin
    pc_d      = pc_q;
    state_d   = state_q;
    slotCnt_d = slotCnt_q;

    if (ctrlRedirect) begin
      pc_d      = ctrl_pc_i;
      state_d   = ST_RUN;
      slotCnt_d = 3'd0;
    end else if (branch_redirect_i) begin
      pc_d      = branch_pc_i;
      state_d   = ST_SLOT;
      slotCnt_d = SLOT_INIT;
    end else begin
      case (state_q)
        ST_BOOT: begin
          state_d = ST_RUN;
        end
        ST_RUN: begin
          if (!holdPc) begin
            pc_d = predPc;
          end
        end
        ST_SLOT: begin
          if (!holdPc) begin
            pc_d = predPc;
            if (slotCnt_q == 3'd1) begin
              state_d   = ST_RUN;
              slotCnt_d = 3'd0;
            end else begin
              slotCnt_d = slotCnt_q - 3'd1;
            end
          end
        end
        default: begin
          state_d   = ST_RUN;
          slotCnt_d = 3'd0;
        end
      endcase
    end
  end

  // State registers with synchronous reset back to BOOT at BOOT_ADDR.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q      <= BOOT_ADDR;
      state_q   <= ST_BOOT;
      slotCnt_q <= 3'd0;
    end else begin
      pc_q      <= pc_d;
      state_q   <= state_d;
      slotCnt_q <= slotCnt_d;
    end
  end

endmodule

// File: tb/tb_ifu_pc_gen.sv
// ---------------------------------------------------------------------------
// tb_ifu_pc_gen
//
// Self-checking bench for ifu_pc_gen.
// A behavioural model tracks the fetch PC, a "just booted" flag and the
// number of unstalled shadow cycles still owed after a branch redirect.
// The predicted successor is computed arithmetically from the instruction
// immediates.
// Directed scenarios come first, then a randomized stretch.
// Build with +define+IFU_STATIC_BP_EN to exercise static prediction.
// ---------------------------------------------------------------------------
module tb_ifu_pc_gen;

  localparam logic [31:0] BOOT_ADDR   = 32'h0000_0000;
  localparam int          SLOT_CYCLES = 2;
  localparam logic [31:0] NOP         = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic        ctrlRedir;
  logic [31:0] ctrlPc;
  logic        brRedir;
  logic [31:0] brPc;
  logic [31:0] inst;
  logic [31:0] pcOut;
  logic [31:0] nextPcOut;
  logic        nextTakenOut;
  logic        slotEndOut;

  int checks = 0;
  int errors = 0;

  // Behavioural model state.
  logic [31:0] mPc;
  bit          mBooting;
  int          mShadow;

  ifu_pc_gen #(
    .BOOT_ADDR  (BOOT_ADDR),
    .SLOT_CYCLES(SLOT_CYCLES)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .stall_i           (stall),
    .flush_i           (flush),
    .ctrl_redirect_pc_i(ctrlRedir),
    .ctrl_pc_i         (ctrlPc),
    .branch_redirect_i (brRedir),
    .branch_pc_i       (brPc),
    .inst_i            (inst),
    .pc_o              (pcOut),
    .next_pc_o         (nextPcOut),
    .next_taken_o      (nextTakenOut),
    .branch_slot_end_o (slotEndOut)
  );

  // Free-running clock with a 10-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Counts one comparison and reports it if the values differ.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %h expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Reference prediction built from the immediate fields with plain arithmetic.
  function automatic logic [32:0] predict(input logic [31:0] pc, input logic [31:0] w,
                                          input bit booting);
    int          imm;
    logic [31:0] tgt;
    predict = {1'b0, pc + 32'd4};
`ifdef IFU_STATIC_BP_EN
    if (!booting) begin
      if (w[6:0] == 7'b1101111) begin
        imm = 2 * int'(w[30:21]) + 2048 * int'(w[20]) + 4096 * int'(w[19:12]);
        if (w[31]) imm = imm - (1 << 20);
        tgt = pc + 32'(imm);
        tgt[0] = 1'b0;
        predict = {1'b1, tgt};
      end else if (w[6:0] == 7'b1100011 && w[31]) begin
        imm = 2 * int'(w[11:8]) + 32 * int'(w[30:25]) + 2048 * int'(w[7]) - 4096;
        tgt = pc + 32'(imm);
        tgt[0] = 1'b0;
        predict = {1'b1, tgt};
      end
    end
`endif
  endfunction

  // Drives one cycle's inputs just after the falling edge, then settles.
  task automatic applyStimulus(input bit r, input logic [5:0] s, input bit f,
                               input bit c, input logic [31:0] cpc, input bit b,
                               input logic [31:0] bpc, input logic [31:0] w);
    rst       = r;
    stall     = s;
    flush     = f;
    ctrlRedir = c;
    ctrlPc    = cpc;
    brRedir   = b;
    brPc      = bpc;
    inst      = w;
    #1;
  endtask

  task automatic idle(input logic [31:0] w);
    applyStimulus(0, 6'd0, 0, 0, 32'd0, 0, 32'd0, w);
  endtask

  // Compares all outputs against the model, then clocks and advances the model.
  task automatic stepCycle();
    logic [32:0] pred;
    bit          expEnd;
    pred   = predict(mPc, inst, mBooting);
    expEnd = (mShadow == 1) && !stall[0] && !rst && !flush && !ctrlRedir;
    checkOutput("pc", pcOut, mPc);
    checkOutput("nextPc", nextPcOut, pred[31:0]);
    checkOutput("taken", {31'd0, nextTakenOut}, {31'd0, pred[32]});
    checkOutput("slotEnd", {31'd0, slotEndOut}, {31'd0, expEnd});
    @(posedge clk);
    if (rst) begin
      mPc = BOOT_ADDR; mBooting = 1; mShadow = 0;
    end else if (flush || ctrlRedir) begin
      mPc = ctrlPc; mBooting = 0; mShadow = 0;
    end else if (brRedir) begin
      mPc = brPc; mBooting = 0; mShadow = SLOT_CYCLES;
    end else if (mBooting) begin
      mBooting = 0;
    end else if (!stall[0]) begin
      mPc = pred[31:0];
      if (mShadow > 0) mShadow--;
    end
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] bootSeq [5];
    logic [31:0] expJal;
    logic [31:0] expBack;
    logic        expBackTaken;
    logic [31:0] r;
    logic [31:0] w;
    bit          rr, ff, cc, bb;
    logic [5:0]  ss;

    bootSeq = '{32'h0, 32'h0, 32'h4, 32'h8, 32'hC};
`ifdef IFU_STATIC_BP_EN
    expJal       = 32'h30;
    expBack      = 32'h38;
    expBackTaken = 1'b1;
`else
    expJal       = 32'h24;
    expBack      = 32'h44;
    expBackTaken = 1'b0;
`endif

    rst = 1; stall = 0; flush = 0; ctrlRedir = 0; ctrlPc = 0;
    brRedir = 0; brPc = 0; inst = NOP;
    @(negedge clk);
    mPc = BOOT_ADDR; mBooting = 1; mShadow = 0;

    // Reset held: reset values.
    applyStimulus(1, 6'd0, 0, 0, 32'd0, 0, 32'd0, NOP);
    checkOutput("rstNextPc", nextPcOut, BOOT_ADDR + 32'd4);
    stepCycle();

    // Release: BOOT holds for one cycle, then sequential fetch.
    for (int i = 0; i < 5; i++) begin
      idle(NOP);
      checkOutput("bootSeq", pcOut, bootSeq[i]);
      checkOutput("bootTaken", {31'd0, nextTakenOut}, 32'd0);
      stepCycle();
    end

    // JAL +16 at 0x20.
    applyStimulus(0, 6'd0, 0, 1, 32'h20, 0, 32'd0, NOP);
    stepCycle();
    idle(32'h0100_006F);
    checkOutput("jalNext", nextPcOut, expJal);
    stepCycle();
    idle(NOP);
    checkOutput("jalPc", pcOut, expJal);
    stepCycle();

    // Backward BEQ -8 at 0x40, then forward BEQ +8 at 0x40.
    applyStimulus(0, 6'd0, 0, 1, 32'h40, 0, 32'd0, NOP);
    stepCycle();
    idle(32'hFE00_0CE3);
    checkOutput("backNext", nextPcOut, expBack);
    checkOutput("backTaken", {31'd0, nextTakenOut}, {31'd0, expBackTaken});
    stepCycle();
    applyStimulus(0, 6'd0, 0, 1, 32'h40, 0, 32'd0, NOP);
    stepCycle();
    idle(32'h0000_0463);
    checkOutput("fwdNext", nextPcOut, 32'h44);
    checkOutput("fwdTaken", {31'd0, nextTakenOut}, 32'd0);
    stepCycle();

    // Wrap-around from the top of the address space.
    applyStimulus(0, 6'd0, 0, 1, 32'hFFFF_FFFC, 0, 32'd0, NOP);
    stepCycle();
    idle(NOP);
    checkOutput("wrapNext", nextPcOut, 32'h0);
    stepCycle();
    idle(NOP);
    checkOutput("wrapPc", pcOut, 32'h0);
    stepCycle();

    // Branch redirect with a stall in the first shadow cycle.
    applyStimulus(0, 6'd0, 0, 0, 32'd0, 1, 32'h100, NOP);
    stepCycle();
    applyStimulus(0, 6'd1, 0, 0, 32'd0, 0, 32'd0, NOP);
    checkOutput("slotPcN1", pcOut, 32'h100);
    checkOutput("slotEndN1", {31'd0, slotEndOut}, 32'd0);
    stepCycle();
    idle(NOP);
    checkOutput("slotPcN2", pcOut, 32'h100);
    checkOutput("slotEndN2", {31'd0, slotEndOut}, 32'd0);
    stepCycle();
    idle(NOP);
    checkOutput("slotEndN3", {31'd0, slotEndOut}, 32'd1);
    stepCycle();
    idle(NOP);
    checkOutput("slotEndN4", {31'd0, slotEndOut}, 32'd0);
    stepCycle();

    // Flush and branch redirect together: flush wins, no shadow.
    applyStimulus(0, 6'd0, 1, 0, 32'h80, 1, 32'h200, NOP);
    stepCycle();
    for (int i = 0; i < 4; i++) begin
      idle(NOP);
      if (i == 0) checkOutput("flushPc", pcOut, 32'h80);
      checkOutput("flushNoEnd", {31'd0, slotEndOut}, 32'd0);
      stepCycle();
    end

    // Reset on the last shadow cycle: no pulse, back to BOOT_ADDR.
    applyStimulus(0, 6'd0, 0, 0, 32'd0, 1, 32'h300, NOP);
    stepCycle();
    idle(NOP);
    stepCycle();
    applyStimulus(1, 6'd0, 0, 0, 32'd0, 0, 32'd0, NOP);
    checkOutput("rstSlotNoEnd", {31'd0, slotEndOut}, 32'd0);
    stepCycle();
    idle(NOP);
    checkOutput("rstSlotPc", pcOut, BOOT_ADDR);
    stepCycle();

    // Randomized traffic checked against the model.
    for (int n = 0; n < 600; n++) begin
      r = $urandom();
      case ($urandom_range(0, 4))
        0: w = NOP;
        1: w = {r[31:7], 7'b1101111};
        2: w = {r[31:7], 7'b1100011};
        3: w = {r[31:7], 7'b1100111};
        default: w = r;
      endcase
      rr = ($urandom_range(0, 63) == 0);
      ff = ($urandom_range(0, 24) == 0);
      cc = ($urandom_range(0, 24) == 0);
      bb = ($urandom_range(0, 9) == 0);
      ss = 6'($urandom());
      ss[0] = ($urandom_range(0, 3) == 0);
      r = $urandom();
      ctrlPc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : {r[31:2], 2'b00};
      r = $urandom();
      applyStimulus(rr, ss, ff, cc, ctrlPc, bb, {r[31:2], 2'b00}, w);
      stepCycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
